// File: rtl/pe_ws_db.sv
// pe_ws_db: weight-stationary MAC processing element with double-buffered
// weights. Activations pass east, partial sums pass south, one beat per cycle.
// Optional feature macro: PE_SAT_EN (saturating sum plus sticky ovf flag).
// Handshake: a_valid_in qualifies a_in/acc_in for the current cycle. There is
// no backpressure. valid_out marks a_out/acc_out one cycle later, and those
// outputs hold their last values while valid_out is low.
module pe_ws_db #(
  parameter int W_WIDTH   = 8,
  parameter int A_WIDTH   = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W_WIDTH-1:0]   w_load_data,
  input  logic                 w_load_en,
  input  logic                 w_swap,
  output logic                 w_shadow_valid,
  input  logic [A_WIDTH-1:0]   a_in,
  input  logic                 a_valid_in,
  input  logic [ACC_WIDTH-1:0] acc_in,
  output logic [A_WIDTH-1:0]   a_out,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 valid_out,
  input  logic                 ovf_clr,
  output logic                 ovf
);

  localparam int P_WIDTH = W_WIDTH + A_WIDTH;

  generate
    if (ACC_WIDTH < P_WIDTH) begin : g_width_check
      $error("pe_ws_db: ACC_WIDTH must be at least W_WIDTH + A_WIDTH");
    end
  endgenerate

  // Shadow-buffer occupancy. The state is exported directly as w_shadow_valid.
  typedef enum logic {
    SH_EMPTY = 1'b0,
    SH_FULL  = 1'b1
  } shadow_state_e;

  shadow_state_e sh_state, sh_state_next;

  logic [W_WIDTH-1:0]          w_active;
  logic [W_WIDTH-1:0]          w_shadow;
  logic signed [P_WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0]        sum;

  // Shadow occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_state <= SH_EMPTY;
    else        sh_state <= sh_state_next;
  end

  // Next occupancy: a load always fills the shadow. A swap empties it only
  // when no new load arrives on the same edge.
  always_comb begin
    sh_state_next = sh_state;
    unique case (sh_state)
      SH_EMPTY: if (w_load_en) sh_state_next = SH_FULL;
      SH_FULL:  if (w_swap && !w_load_en) sh_state_next = SH_EMPTY;
      default:  sh_state_next = SH_EMPTY;
    endcase
  end

  assign w_shadow_valid = (sh_state == SH_FULL);

  // Weight registers. The active weight changes only on a swap with a full
  // shadow, so a beat on the same edge still multiplies by the old weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_active <= '0;
      w_shadow <= '0;
    end else begin
      if (w_swap && sh_state == SH_FULL) w_active <= w_shadow;
      if (w_load_en)                     w_shadow <= w_load_data;
    end
  end

  // Full-precision signed product, sign-extended to the partial-sum width.
  assign prod     = P_WIDTH'($signed(w_active)) * P_WIDTH'($signed(a_in));
  assign prod_ext = ACC_WIDTH'(prod);

`ifdef PE_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum_wide;
  logic                      sum_ovf;

  assign sum_wide = (ACC_WIDTH+1)'($signed(acc_in)) + (ACC_WIDTH+1)'(prod_ext);
  assign sum_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];

  // Clamp toward the sign of the true (one-bit-wider) result on overflow.
  always_comb begin
    sum = sum_wide[ACC_WIDTH-1:0];
    if (sum_ovf) sum = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  // Sticky overflow flag. A clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ovf <= 1'b0;
    else if (ovf_clr)                 ovf <= 1'b0;
    else if (a_valid_in && sum_ovf)   ovf <= 1'b1;
  end
`else
  logic unused_ovf_clr;

  assign sum            = acc_in + prod_ext;
  assign ovf            = 1'b0;
  assign unused_ovf_clr = ovf_clr;
`endif

  // Forwarding stage. Outputs load on a valid beat and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      acc_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= a_valid_in;
      if (a_valid_in) begin
        a_out   <= a_in;
        acc_out <= sum;
      end
    end
  end

endmodule
